// File: rtl/vx_fifo_bank.sv
// vx_fifo_bank: NUM_QUEUES independent first-word-fall-through FIFOs sharing one push port and one pop port.
// Optional push/pop error reporting is enabled by defining FIFO_BANK_CHECK_EN.
module vx_fifo_bank #(
  parameter int DATAW      = 8,
  parameter int DEPTH      = 4,
  parameter int NUM_QUEUES = 2,
  parameter int ALM_FULL   = DEPTH - 1,
  parameter int ALM_EMPTY  = 1,
  localparam int QIDW      = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1,
  localparam int SIZEW     = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic [QIDW-1:0]             push_qid,
  input  logic [DATAW-1:0]            data_in,
  input  logic                        pop,
  input  logic [QIDW-1:0]             pop_qid,
  output logic [DATAW-1:0]            data_out,
  output logic [NUM_QUEUES-1:0]       empty,
  output logic [NUM_QUEUES-1:0]       full,
  output logic [NUM_QUEUES-1:0]       alm_empty,
  output logic [NUM_QUEUES-1:0]       alm_full,
  output logic [NUM_QUEUES*SIZEW-1:0] size,
  output logic                        err_overflow,
  output logic                        err_underflow
);

  localparam int PTRW = $clog2(DEPTH);

  logic [DATAW-1:0]      r_mem      [NUM_QUEUES][DEPTH];
  logic [PTRW-1:0]       r_wr_ptr   [NUM_QUEUES];
  logic [PTRW-1:0]       r_rd_ptr   [NUM_QUEUES];
  logic [SIZEW-1:0]      r_size     [NUM_QUEUES];
  logic [SIZEW-1:0]      w_size_nxt [NUM_QUEUES];
  logic [NUM_QUEUES-1:0] r_empty;
  logic [NUM_QUEUES-1:0] r_full;
  logic [NUM_QUEUES-1:0] r_alm_empty;
  logic [NUM_QUEUES-1:0] r_alm_full;
  logic [NUM_QUEUES-1:0] w_push_q;
  logic [NUM_QUEUES-1:0] w_pop_q;
  logic [DATAW-1:0]      w_data_out;

  // Per-queue accept decode; a full queue may take a push only while it is being popped.
  // Out-of-range queue IDs match no queue and are therefore dropped/ignored.
  always_comb begin
    w_push_q = '0;
    w_pop_q  = '0;
    for (int q = 0; q < NUM_QUEUES; q++) begin
      w_pop_q[q]    = pop && (pop_qid == QIDW'(q)) && !r_empty[q];
      w_push_q[q]   = push && (push_qid == QIDW'(q)) && (!r_full[q] || w_pop_q[q]);
      w_size_nxt[q] = r_size[q] + SIZEW'(w_push_q[q]) - SIZEW'(w_pop_q[q]);
    end
  end

  // Pointers, occupancy and status flags; flags are derived from the next size so they stay registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int q = 0; q < NUM_QUEUES; q++) begin
        r_wr_ptr[q] <= '0;
        r_rd_ptr[q] <= '0;
        r_size[q]   <= '0;
      end
      r_empty     <= '1;
      r_full      <= '0;
      r_alm_empty <= '1;
      r_alm_full  <= '0;
    end else begin
      for (int q = 0; q < NUM_QUEUES; q++) begin
        if (w_push_q[q]) begin
          r_wr_ptr[q] <= r_wr_ptr[q] + PTRW'(1);
        end
        if (w_pop_q[q]) begin
          r_rd_ptr[q] <= r_rd_ptr[q] + PTRW'(1);
        end
        r_size[q]      <= w_size_nxt[q];
        r_empty[q]     <= (w_size_nxt[q] == SIZEW'(0));
        r_full[q]      <= (w_size_nxt[q] == SIZEW'(DEPTH));
        r_alm_empty[q] <= (w_size_nxt[q] <= SIZEW'(ALM_EMPTY));
        r_alm_full[q]  <= (w_size_nxt[q] >= SIZEW'(ALM_FULL));
      end
    end
  end

  // Payload storage is intentionally left unreset.
  always_ff @(posedge clk) begin
    for (int q = 0; q < NUM_QUEUES; q++) begin
      if (w_push_q[q]) begin
        r_mem[q][r_wr_ptr[q]] <= data_in;
      end
    end
  end

  // Head-of-queue read mux selected by pop_qid.
  always_comb begin
    w_data_out = '0;
    for (int q = 0; q < NUM_QUEUES; q++) begin
      if (pop_qid == QIDW'(q)) begin
        w_data_out = r_mem[q][r_rd_ptr[q]];
      end else begin
        w_data_out = w_data_out;
      end
    end
  end

  assign data_out  = w_data_out;
  assign empty     = r_empty;
  assign full      = r_full;
  assign alm_empty = r_alm_empty;
  assign alm_full  = r_alm_full;

  for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_size
    assign size[g*SIZEW +: SIZEW] = r_size[g];
  end

`ifdef FIFO_BANK_CHECK_EN
  logic r_err_ovf;
  logic r_err_udf;

  // One-cycle pulses for a dropped push or an ignored pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_ovf <= 1'b0;
      r_err_udf <= 1'b0;
    end else begin
      r_err_ovf <= push && (w_push_q == '0);
      r_err_udf <= pop && (w_pop_q == '0);
    end
  end

  assign err_overflow  = r_err_ovf;
  assign err_underflow = r_err_udf;

  vx_fifo_bank_chk u_chk (
    .clk           (clk),
    .reset         (reset),
    .err_overflow  (r_err_ovf),
    .err_underflow (r_err_udf)
  );
`else
  assign err_overflow  = 1'b0;
  assign err_underflow = 1'b0;
`endif

endmodule

`ifdef FIFO_BANK_CHECK_EN
// Simulation reporter for the error pulses raised by vx_fifo_bank.
module vx_fifo_bank_chk (
  input logic clk,
  input logic reset,
  input logic err_overflow,
  input logic err_underflow
);

  // Report each error pulse once, in the cycle it is asserted.
  always_ff @(posedge clk) begin
    if (!reset && err_overflow) begin
      $error("vx_fifo_bank: push to full queue dropped");
    end
    if (!reset && err_underflow) begin
      $error("vx_fifo_bank: pop from empty queue ignored");
    end
  end

endmodule
`endif

// File: tb/tb_vx_fifo_bank.sv
// Directed bench for vx_fifo_bank (DATAW=4, DEPTH=4, NUM_QUEUES=2, ALM_FULL=3, ALM_EMPTY=1).
module tb_vx_fifo_bank;

`ifdef FIFO_BANK_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       push;
  logic [0:0] push_qid;
  logic [3:0] data_in;
  logic       pop;
  logic [0:0] pop_qid;
  logic [3:0] data_out;
  logic [1:0] empty;
  logic [1:0] full;
  logic [1:0] alm_empty;
  logic [1:0] alm_full;
  logic [5:0] size;
  logic       err_overflow;
  logic       err_underflow;

  int checks   = 0;
  int failures = 0;

  vx_fifo_bank #(
    .DATAW(4), .DEPTH(4), .NUM_QUEUES(2), .ALM_FULL(3), .ALM_EMPTY(1)
  ) dut (
    .clk(clk), .reset(reset), .push(push), .push_qid(push_qid), .data_in(data_in),
    .pop(pop), .pop_qid(pop_qid), .data_out(data_out), .empty(empty), .full(full),
    .alm_empty(alm_empty), .alm_full(alm_full), .size(size),
    .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, sample 1 time unit after the rising edge.
  task automatic cyc(input logic p, input logic [0:0] pq, input logic [3:0] d,
                     input logic pp, input logic [0:0] ppq);
    push = p; push_qid = pq; data_in = d; pop = pp; pop_qid = ppq;
    @(posedge clk);
    #1;
    push = 1'b0;
    pop  = 1'b0;
  endtask

  logic [3:0] exp_q [4];

  initial begin
    reset = 1'b1; push = 1'b0; pop = 1'b0;
    push_qid = 1'b0; pop_qid = 1'b0; data_in = 4'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    chk("rst_empty", 32'(empty), 32'h3);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_alm_empty", 32'(alm_empty), 32'h3);
    chk("rst_alm_full", 32'(alm_full), 32'h0);
    chk("rst_size", 32'(size), 32'h0);
    chk("rst_err_ovf", 32'(err_overflow), 32'h0);
    chk("rst_err_udf", 32'(err_underflow), 32'h0);

    // Fill q0 with A,B,C,D
    cyc(1'b1, 1'b0, 4'hA, 1'b0, 1'b0);
    chk("fill1_size", 32'(size), 32'(6'o01));
    chk("fill1_empty", 32'(empty), 32'h2);
    chk("fill1_alm_empty", 32'(alm_empty), 32'h3);
    cyc(1'b1, 1'b0, 4'hB, 1'b0, 1'b0);
    chk("fill2_alm_empty", 32'(alm_empty), 32'h2);
    chk("fill2_alm_full", 32'(alm_full), 32'h0);
    cyc(1'b1, 1'b0, 4'hC, 1'b0, 1'b0);
    chk("fill3_alm_full", 32'(alm_full), 32'h1);
    chk("fill3_full", 32'(full), 32'h0);
    cyc(1'b1, 1'b0, 4'hD, 1'b0, 1'b0);
    chk("fill4_full", 32'(full), 32'h1);
    chk("fill4_size", 32'(size), 32'(6'o04));
    chk("fill4_empty", 32'(empty), 32'h2);
    chk("fill4_head", 32'(data_out), 32'hA);

    // Overflow: push to full q0 is dropped
    cyc(1'b1, 1'b0, 4'hE, 1'b0, 1'b0);
    chk("ovf_err", 32'(err_overflow), 32'(CHK));
    chk("ovf_size", 32'(size), 32'(6'o04));
    chk("ovf_full", 32'(full), 32'h1);
    cyc(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    chk("ovf_err_clear", 32'(err_overflow), 32'h0);
    chk("ovf_head", 32'(data_out), 32'hA);

    exp_q[0] = 4'hA; exp_q[1] = 4'hB; exp_q[2] = 4'hC; exp_q[3] = 4'hD;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain1_%0d", i), 32'(data_out), 32'(exp_q[i]));
      cyc(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
      chk($sformatf("drain1_size_%0d", i), 32'(size), 32'(3 - i));
      chk($sformatf("drain1_udf_%0d", i), 32'(err_underflow), 32'h0);
    end
    chk("drain1_empty", 32'(empty), 32'h3);
    chk("drain1_alm_full", 32'(alm_full), 32'h0);

    // Interleave: push q1 while popping q0
    cyc(1'b1, 1'b0, 4'h5, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 4'h6, 1'b0, 1'b0);
    chk("intl_pre_size", 32'(size), 32'(6'o02));
    cyc(1'b1, 1'b1, 4'h1, 1'b1, 1'b0);
    chk("intl_size", 32'(size), 32'(6'o11));
    chk("intl_empty", 32'(empty), 32'h0);
    chk("intl_err_ovf", 32'(err_overflow), 32'h0);
    pop_qid = 1'b1; #1;
    chk("intl_q1_head", 32'(data_out), 32'h1);
    pop_qid = 1'b0; #1;
    chk("intl_q0_head", 32'(data_out), 32'h6);
    cyc(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
    chk("intl_clean_empty", 32'(empty), 32'h3);
    chk("intl_clean_size", 32'(size), 32'h0);

    // Full queue push + pop in the same cycle
    cyc(1'b1, 1'b0, 4'hA, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 4'hB, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 4'hC, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 4'hD, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 4'hE, 1'b1, 1'b0);
    chk("fpp_size", 32'(size), 32'(6'o04));
    chk("fpp_full", 32'(full), 32'h1);
    chk("fpp_err_ovf", 32'(err_overflow), 32'h0);
    exp_q[0] = 4'hB; exp_q[1] = 4'hC; exp_q[2] = 4'hD; exp_q[3] = 4'hE;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain2_%0d", i), 32'(data_out), 32'(exp_q[i]));
      cyc(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    end
    chk("drain2_empty", 32'(empty), 32'h3);

    // Wrap: eight push/pop pairs through q1
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b1, 4'(i + 3), 1'b0, 1'b1);
      chk($sformatf("wrap_head_%0d", i), 32'(data_out), 32'(i + 3));
      chk($sformatf("wrap_size_%0d", i), 32'(size), 32'(6'o10));
      cyc(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
      chk($sformatf("wrap_empty_%0d", i), 32'(empty), 32'h3);
    end

    // Empty queue push + pop: push taken, pop ignored, no bypass
    cyc(1'b1, 1'b1, 4'h9, 1'b1, 1'b1);
    chk("epp_size", 32'(size), 32'(6'o10));
    chk("epp_head", 32'(data_out), 32'h9);
    cyc(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
    chk("epp_drain_size", 32'(size), 32'h0);

    // Underflow on empty q1
    cyc(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
    chk("udf_err", 32'(err_underflow), 32'(CHK));
    chk("udf_size", 32'(size), 32'h0);
    chk("udf_empty", 32'(empty), 32'h3);
    cyc(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    chk("udf_err_clear", 32'(err_underflow), 32'h0);

    // Asynchronous reset mid-operation
    cyc(1'b1, 1'b1, 4'h7, 1'b0, 1'b1);
    chk("arst_pre_size", 32'(size), 32'(6'o10));
    #2 reset = 1'b1;
    #1;
    chk("arst_empty", 32'(empty), 32'h3);
    chk("arst_size", 32'(size), 32'h0);
    chk("arst_alm_empty", 32'(alm_empty), 32'h3);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("arst_post_empty", 32'(empty), 32'h3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vx_fifo_bank.md
# vx_fifo_bank

Bank of NUM_QUEUES independent first-word-fall-through FIFO queues with one shared push port and one shared pop port, each selected by a queue ID. It generalises the single-queue FIFO to multi-channel buffering for per-warp or per-bank request staging in the core and cache front-ends. It adds programmable almost-full and almost-empty thresholds, per-queue occupancy, and optional push/pop error detection.

## Interface
- DATAW, 8, payload width in bits
- DEPTH, 4, entries per queue; power of two, ≥ 2
- NUM_QUEUES, 2, number of independent queues; ≥ 1
- ALM_FULL, DEPTH-1, almost-full threshold; 1..DEPTH
- ALM_EMPTY, 1, almost-empty threshold; 0..DEPTH-1
- QIDW = max(1, $clog2(NUM_QUEUES)); SIZEW = $clog2(DEPTH+1) (derived, not overridable)

- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- push  in  1  write data_in into queue push_qid
- push_qid  in  QIDW  target queue for push
- data_in  in  DATAW  push payload
- pop  in  1  remove head of queue pop_qid
- pop_qid  in  QIDW  source queue for pop and data_out
- data_out  out  DATAW  head entry of queue pop_qid (combinational on pop_qid)
- empty  out  NUM_QUEUES  bit q: queue q holds 0 entries
- full  out  NUM_QUEUES  bit q: queue q holds DEPTH entries
- alm_empty  out  NUM_QUEUES  bit q: size_q ≤ ALM_EMPTY
- alm_full  out  NUM_QUEUES  bit q: size_q ≥ ALM_FULL
- size  out  NUM_QUEUES*SIZEW  occupancy, queue q at bits [q*SIZEW +: SIZEW]
- err_overflow  out  1  one-cycle pulse on a dropped push
- err_underflow  out  1  one-cycle pulse on an ignored pop

## Operation
- Each queue has private storage of DEPTH×DATAW, read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, and a SIZEW-bit counter.
- The push is accepted when push=1 and either (full[push_qid]=0) or (pop=1, pop_qid=push_qid, and that queue is full). An accepted push writes to wr_ptr, increments wr_ptr, and increments size, unless a pop is accepted on the same queue.
- The pop is accepted when pop=1 and empty[pop_qid]=0. An accepted pop increments rd_ptr and decrements size, unless a push is accepted on the same queue.
- Push and pop on the same queue in one cycle, queue neither empty nor full: both take effect and size is unchanged.
- Same queue, full, push and pop: both are accepted and size stays DEPTH.
- Same queue, empty, push and pop: the push is accepted, the pop is ignored, and size becomes 1. There is no bypass of data_in to data_out.
- Push and pop on different queues are fully independent.
- A push to a full queue (no same-queue pop) is dropped, and storage and pointers are unchanged.
- A pop from an empty queue is ignored.
- push_qid or pop_qid ≥ NUM_QUEUES is treated as a dropped push or an ignored pop, respectively.
- data_out = storage_q[rd_ptr_q] for q = pop_qid. When that queue is empty, the value is stale and undefined; checkers must not compare it.
- Storage is not reset. Pointers, counters, and flags are reset.

## Timing
- Reset (async assert, sync deassert by the system): all pointers and size = 0, empty = all 1s, full = 0, alm_empty = all 1s (ALM_EMPTY ≥ 0), alm_full = 0, err_* = 0.
- Write latency is 1 cycle. A word pushed at edge N is visible on data_out (if it is the head) and in size/flags after edge N.
- Pop latency is 1 cycle. The next head appears on data_out after the popping edge.
- empty, full, alm_empty, alm_full, and size are registered, with no combinational path from push or pop.
- data_out has a combinational path only from pop_qid and state.
- err_* are registered. They assert for exactly the cycle after the offending edge.
- Reset asserted mid-operation clears all queues immediately; in-flight pushes are lost.

## Configuration
- FIFO_BANK_CHECK_EN defined: err_overflow and err_underflow behave as described above, and simulation also emits $error on each event.
- FIFO_BANK_CHECK_EN undefined: err_overflow and err_underflow are tied to 0. Drop and ignore semantics are unchanged.

## Test plan
Configuration for all scenarios: DATAW=4, DEPTH=4, NUM_QUEUES=2, ALM_FULL=3, ALM_EMPTY=1.
- Reset: after reset, empty=2'b11, full=0, alm_empty=2'b11, size=0, err_*=0.
- Fill q0: push a,b,c,d to q0. After the 3rd push alm_full[0]=1. After the 4th, full[0]=1 and size q0=4, with q1 still empty. Reading pop_qid=0 gives data_out=a.
- Overflow: push e to full q0. The push is dropped, err_overflow pulses once (CHECK_EN), and popping four times yields a,b,c,d, then empty[0]=1.
- Interleave: push 1 to q1 and pop q0 in the same cycle. Both succeed. data_out for pop_qid=1 is 1, and size q0 decrements.
- Full-queue push+pop: q0 holds a,b,c,d; push e and pop q0 together. size stays 4 and the drain order is b,c,d,e.
- Wrap and underflow: cycle eight push/pop pairs through q1 (pointers wrap twice) with order preserved. A pop on empty q1 is ignored, err_underflow pulses, and size stays 0.
